// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter
//   Two-master arbiter in front of a single cache port. It keeps at most one
//   transaction outstanding. The winner's request fields are latched on
//   accept. They are presented downstream until the cache grants. The
//   response, or a timeout error, is returned to the owner for exactly one
//   cycle.
//
// Ports
//   clk, reset_n                      clock, asynchronous active-low reset
//   m0_*_i / m1_*_i                   master requests: req, addr, wdata, we, be
//   m0_*_o / m1_*_o                   master responses: gnt, rvalid, rdata, error
//   s_req_o .. s_be_o                 downstream request, valid only in Issue
//   s_gnt_i, s_rvalid_i, s_rdata_i,   downstream grant and response
//   s_error_i
//   dbg_state                         current FSM state (Idle=0 Issue=1 Wait=2 Resp=3)
//
// Handshake
//   A master holds req until it sees gnt. gnt is combinational in the Idle
//   cycle that accepts the request. Downstream, s_req_o stays high with
//   stable fields until s_gnt_i is sampled high. s_rvalid_i may arrive in the
//   grant cycle or in any later cycle. Grants or responses seen outside
//   Issue/Wait are dropped.
module cache_port_arbiter #(
  parameter int RR_ENABLE      = 1,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_req_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic        m1_req_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_error_o,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_error_o,
  output logic        s_req_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_wdata_o,
  output logic        s_we_o,
  output logic [3:0]  s_be_o,
  input  logic        s_gnt_i,
  input  logic        s_rvalid_i,
  input  logic [31:0] s_rdata_i,
  input  logic        s_error_i,
  output logic [1:0]  dbg_state
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            last_owner_q;
  logic            owner_q;
  logic [31:0]     addr_q, wdata_q, rdata_q;
  logic            we_q, error_q;
  logic [3:0]      be_q;
  logic [CW-1:0]   cnt_q;

  logic            any_req, win1, accept, busy, complete, timeout;
  logic            rvalid0, rvalid1;

  // Arbitration: a tie goes to the master that was not served last
  // (round-robin), or always to master 0 (fixed priority).
  always_comb begin
    any_req = m0_req_i | m1_req_i;
    if (m0_req_i && m1_req_i) begin
      win1 = (RR_ENABLE != 0) ? ~last_owner_q : 1'b0;
    end else begin
      win1 = m1_req_i;
    end
    accept   = (state_q == IDLE) && any_req;
    busy     = (state_q == ISSUE) || (state_q == WAIT);
    complete = ((state_q == ISSUE) && s_gnt_i && s_rvalid_i) ||
               ((state_q == WAIT) && s_rvalid_i);
    // A real completion in the last allowed cycle beats the timeout.
    timeout  = busy && (cnt_q == CW'(TIMEOUT_CYCLES - 1)) && !complete;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE: begin
        if (complete || timeout) state_d = RESP;
        else if (s_gnt_i)        state_d = WAIT;
      end
      WAIT:    if (complete || timeout) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      owner_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      be_q         <= '0;
      rdata_q      <= '0;
      error_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q <= win1;
        addr_q  <= win1 ? m1_addr_i  : m0_addr_i;
        wdata_q <= win1 ? m1_wdata_i : m0_wdata_i;
        we_q    <= win1 ? m1_we_i    : m0_we_i;
        be_q    <= win1 ? m1_be_i    : m0_be_i;
        cnt_q   <= '0;
      end
      if (busy) cnt_q <= cnt_q + CW'(1);
      if (complete) begin
        rdata_q <= s_rdata_i;
        error_q <= s_error_i;
      end else if (timeout) begin
        rdata_q <= '0;
        error_q <= 1'b1;
      end
      if (state_q == RESP) last_owner_q <= owner_q;
    end
  end

  // gnt is combinational from the request, so it is masked during reset.
  assign m0_gnt_o    = reset_n & accept & ~win1;
  assign m1_gnt_o    = reset_n & accept & win1;
  assign rvalid0     = (state_q == RESP) && !owner_q;
  assign rvalid1     = (state_q == RESP) && owner_q;
  assign m0_rvalid_o = rvalid0;
  assign m1_rvalid_o = rvalid1;
  assign m0_rdata_o  = rdata_q;
  assign m1_rdata_o  = rdata_q;
  assign m0_error_o  = error_q & rvalid0;
  assign m1_error_o  = error_q & rvalid1;
  assign s_req_o     = (state_q == ISSUE);
  assign s_addr_o    = addr_q;
  assign s_wdata_o   = wdata_q;
  assign s_we_o      = we_q;
  assign s_be_o      = be_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// tb_cache_port_arbiter
//   Bench for cache_port_arbiter. The main instance uses round-robin with a
//   16-cycle timeout. A second instance uses fixed priority and is served by
//   an always-ready slave. The main instance is driven one cycle at a time
//   from a transaction task. The task computes the winner, the response cycle
//   and the response data from the arbitration and timeout rules.
module tb_cache_port_arbiter;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m0_req, m1_req, m0_we, m1_we;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_be, m1_be;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_error, m1_error;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_req, s_we, s_gnt, s_rvalid, s_error;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_be;
  logic [1:0]  dbg_state;

  logic        fp_r0, fp_r1;
  logic        fp_m0_gnt, fp_m1_gnt, fp_m0_rvalid, fp_m1_rvalid, fp_m0_error, fp_m1_error;
  logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_s_addr, fp_s_wdata;
  logic        fp_s_req, fp_s_we;
  logic [3:0]  fp_s_be;
  logic [1:0]  fp_dbg_state;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];
  int          model_last = 1;

  always #5 clk = ~clk;

  cache_port_arbiter #(.RR_ENABLE(1), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata), .m0_we_i(m0_we), .m0_be_i(m0_be),
    .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata), .m1_we_i(m1_we), .m1_be_i(m1_be),
    .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata), .m0_error_o(m0_error),
    .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata), .m1_error_o(m1_error),
    .s_req_o(s_req), .s_addr_o(s_addr), .s_wdata_o(s_wdata), .s_we_o(s_we), .s_be_o(s_be),
    .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata), .s_error_i(s_error),
    .dbg_state(dbg_state)
  );

  cache_port_arbiter #(.RR_ENABLE(0), .TIMEOUT_CYCLES(TMO)) fp (
    .clk(clk), .reset_n(reset_n),
    .m0_req_i(fp_r0), .m0_addr_i(32'h0000_0040), .m0_wdata_i(32'h0), .m0_we_i(1'b0), .m0_be_i(4'hF),
    .m1_req_i(fp_r1), .m1_addr_i(32'h0000_0080), .m1_wdata_i(32'h0), .m1_we_i(1'b0), .m1_be_i(4'hF),
    .m0_gnt_o(fp_m0_gnt), .m0_rvalid_o(fp_m0_rvalid), .m0_rdata_o(fp_m0_rdata), .m0_error_o(fp_m0_error),
    .m1_gnt_o(fp_m1_gnt), .m1_rvalid_o(fp_m1_rvalid), .m1_rdata_o(fp_m1_rdata), .m1_error_o(fp_m1_error),
    .s_req_o(fp_s_req), .s_addr_o(fp_s_addr), .s_wdata_o(fp_s_wdata), .s_we_o(fp_s_we), .s_be_o(fp_s_be),
    .s_gnt_i(1'b1), .s_rvalid_i(1'b1), .s_rdata_i(32'h5555_AAAA), .s_error_i(1'b0),
    .dbg_state(fp_dbg_state)
  );

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic scramble_masters();
    m0_addr  = $urandom; m1_addr  = $urandom;
    m0_wdata = $urandom; m1_wdata = $urandom;
    m0_we    = 1'($urandom_range(0, 1)); m1_we = 1'($urandom_range(0, 1));
    m0_be    = 4'($urandom); m1_be = 4'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    check1({tag, "_gnt0"}, m0_gnt, 1'b0);
    check1({tag, "_gnt1"}, m1_gnt, 1'b0);
    check1({tag, "_rv0"}, m0_rvalid, 1'b0);
    check1({tag, "_rv1"}, m1_rvalid, 1'b0);
    check1({tag, "_err0"}, m0_error, 1'b0);
    check1({tag, "_err1"}, m1_error, 1'b0);
    check32({tag, "_rdata"}, m0_rdata, 32'h0);
    check1({tag, "_sreq"}, s_req, 1'b0);
    check32({tag, "_saddr"}, s_addr, 32'h0);
    check32({tag, "_swdata"}, s_wdata, 32'h0);
    check1({tag, "_swe"}, s_we, 1'b0);
    check32({tag, "_sbe"}, {28'h0, s_be}, 32'h0);
    check32({tag, "_state"}, {30'h0, dbg_state}, 32'h0);
  endtask

  // One transaction starting in an Idle cycle. gd is the number of Issue cycles
  // before the grant. rd is the number of cycles from grant to rvalid (0 means
  // the same cycle). exp_win >= 0 forces the expected winner from a table.
  task automatic do_txn(input logic r0, input logic r1,
                        input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] wd0, input logic [31:0] wd1,
                        input logic [1:0] we, input logic [3:0] be0, input logic [3:0] be1,
                        input int gd, input int rd, input logic [31:0] rdata,
                        input logic err, input int exp_win);
    int win, c, stop;
    logic [31:0] ea, ew, exp_data, got;
    logic ewe, exp_err, rv_now;
    logic [3:0] ebe;
    if (r0 && r1) win = (model_last == 1) ? 0 : 1;
    else          win = r0 ? 0 : 1;
    if (exp_win >= 0) win = exp_win;
    ea  = (win == 0) ? a0  : a1;
    ew  = (win == 0) ? wd0 : wd1;
    ewe = (win == 0) ? we[0] : we[1];
    ebe = (win == 0) ? be0 : be1;
    c = gd + 1 + rd;
    if (c > TMO) begin
      stop = TMO; exp_data = 32'h0; exp_err = 1'b1;
    end else begin
      stop = c; exp_data = rdata; exp_err = err;
    end
    // accept cycle
    @(negedge clk);
    m0_req = r0; m1_req = r1;
    m0_addr = a0; m1_addr = a1; m0_wdata = wd0; m1_wdata = wd1;
    m0_we = we[0]; m1_we = we[1]; m0_be = be0; m1_be = be1;
    s_gnt = 1'($urandom_range(0, 1)); s_rvalid = 1'($urandom_range(0, 1));
    s_rdata = $urandom; s_error = 1'($urandom_range(0, 1));
    #1;
    check1("accept_gnt0", m0_gnt, win == 0);
    check1("accept_gnt1", m1_gnt, win == 1);
    check1("idle_rv0", m0_rvalid, 1'b0);
    check1("idle_rv1", m1_rvalid, 1'b0);
    exp_q.push_back(exp_data);
    // Issue / Wait cycles
    for (int k = 1; k <= stop; k++) begin
      @(negedge clk);
      if (win == 0) m0_req = 1'b0; else m1_req = 1'b0;
      scramble_masters();
      s_gnt  = (k == gd + 1);
      rv_now = (rd == 0) ? (k == gd + 1) : (k == gd + 1 + rd);
      s_rvalid = rv_now;
      s_rdata  = rv_now ? rdata : $urandom;
      s_error  = rv_now ? err : 1'($urandom_range(0, 1));
      #1;
      check1("busy_sreq", s_req, k <= gd + 1);
      if (k <= gd + 1) begin
        check32("issue_addr", s_addr, ea);
        check32("issue_wdata", s_wdata, ew);
        check1("issue_we", s_we, ewe);
        check32("issue_be", {28'h0, s_be}, {28'h0, ebe});
      end
      check1("busy_gnt0", m0_gnt, 1'b0);
      check1("busy_gnt1", m1_gnt, 1'b0);
      check1("busy_rv0", m0_rvalid, 1'b0);
      check1("busy_rv1", m1_rvalid, 1'b0);
    end
    // Resp cycle; a stray grant/response here must be ignored
    @(negedge clk);
    m0_req = 1'b0; m1_req = 1'b0;
    s_gnt = 1'b1; s_rvalid = 1'b1; s_rdata = $urandom; s_error = 1'b1;
    #1;
    got = exp_q.pop_front();
    check1("resp_rv0", m0_rvalid, win == 0);
    check1("resp_rv1", m1_rvalid, win == 1);
    check32("resp_rdata0", m0_rdata, got);
    check32("resp_rdata1", m1_rdata, got);
    check1("resp_error", (win == 0) ? m0_error : m1_error, exp_err);
    check1("resp_other_err", (win == 0) ? m1_error : m0_error, 1'b0);
    check1("resp_sreq", s_req, 1'b0);
    model_last = win;
  endtask

  typedef struct {
    logic        r0, r1;
    logic [31:0] a0, a1, wd0, wd1;
    logic [1:0]  we;
    logic [3:0]  be0, be1;
    int          gd, rd;
    logic [31:0] rdata;
    logic        err;
    int          exp_win;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int n0, n1;
    logic r0, r1;
    tbl[0] = '{1'b1, 1'b1, 32'h10, 32'h14, 32'h1, 32'h2, 2'b00, 4'hF, 4'hF, 0, 1, 32'h1111_0000, 1'b0, 0};
    tbl[1] = '{1'b1, 1'b1, 32'h20, 32'h24, 32'h3, 32'h4, 2'b01, 4'h1, 4'h2, 1, 0, 32'h2222_0000, 1'b0, 1};
    tbl[2] = '{1'b1, 1'b1, 32'h30, 32'h34, 32'h5, 32'h6, 2'b10, 4'h4, 4'h8, 0, 2, 32'h3333_0000, 1'b1, 0};
    tbl[3] = '{1'b1, 1'b1, 32'h40, 32'h200, 32'h7, 32'h1234_5678, 2'b10, 4'hC, 4'b0011, 3, 2, 32'h4444_0000, 1'b0, 1};
    tbl[4] = '{1'b1, 1'b0, 32'h100, 32'h0, 32'h0, 32'h0, 2'b00, 4'hF, 4'h0, 2, 3, 32'hDEAD_BEEF, 1'b0, 0};
    tbl[5] = '{1'b0, 1'b1, 32'h0, 32'h500, 32'h0, 32'h9, 2'b00, 4'h0, 4'hF, 1, 0, 32'hA5A5_A5A5, 1'b0, 1};
    tbl[6] = '{1'b1, 1'b0, 32'h600, 32'h0, 32'h0, 32'h0, 2'b00, 4'hF, 4'h0, 100, 0, 32'hFFFF_FFFF, 1'b0, 0};
    tbl[7] = '{1'b1, 1'b1, 32'h700, 32'h704, 32'h0, 32'h0, 2'b00, 4'hF, 4'hF, 10, 5, 32'hC0FF_EE00, 1'b1, 1};

    // clock/reset
    reset_n = 1'b0;
    m0_req = 1'b1; m1_req = 1'b1;
    scramble_masters();
    s_gnt = 1'b1; s_rvalid = 1'b1; s_rdata = 32'hFFFF_FFFF; s_error = 1'b1;
    fp_r0 = 1'b1; fp_r1 = 1'b1;
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    m0_req = 1'b0; m1_req = 1'b0; s_gnt = 1'b0; s_rvalid = 1'b0;
    reset_n = 1'b1;

    // idle on the main instance; fixed priority on fp with both requesting
    n0 = 0; n1 = 0;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      #1;
      check1("idle_sreq", s_req, 1'b0);
      check1("idle_gnt0", m0_gnt, 1'b0);
      check1("idle_gnt1", m1_gnt, 1'b0);
      if (fp_m0_gnt) n0++;
      if (fp_m1_gnt) n1++;
    end
    check32("fp_m0_wins", n0, 7);
    check32("fp_m1_wins", n1, 0);
    fp_r0 = 1'b0;
    n1 = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      if (fp_m1_gnt) n1++;
    end
    check32("fp_m1_alone", n1, 2);

    // table vectors
    for (int i = 0; i < 8; i++) begin
      do_txn(tbl[i].r0, tbl[i].r1, tbl[i].a0, tbl[i].a1, tbl[i].wd0, tbl[i].wd1,
             tbl[i].we, tbl[i].be0, tbl[i].be1, tbl[i].gd, tbl[i].rd,
             tbl[i].rdata, tbl[i].err, tbl[i].exp_win);
    end

    // randomized transactions against the model
    for (int i = 0; i < 40; i++) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
      do_txn(r0, r1, $urandom, $urandom, $urandom, $urandom, 2'($urandom),
             4'($urandom), 4'($urandom), $urandom_range(0, 9), $urandom_range(0, 9),
             $urandom, 1'($urandom_range(0, 1)), -1);
    end

    // reset during Wait
    @(negedge clk);
    m0_req = 1'b1; m1_req = 1'b0; m0_addr = 32'hABC0; s_gnt = 1'b0; s_rvalid = 1'b0;
    #1;
    check1("rstw_accept", m0_gnt, 1'b1);
    @(negedge clk);
    m0_req = 1'b0; s_gnt = 1'b1;
    @(negedge clk);
    s_gnt = 1'b0;
    #1;
    check32("rstw_in_wait", {30'h0, dbg_state}, 32'd2);
    m0_req = 1'b1; m1_req = 1'b1;
    reset_n = 1'b0;
    #1;
    check_all_zero("rstw");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    m0_req = 1'b0; m1_req = 1'b0;
    exp_q.delete();
    model_last = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      s_rvalid = (i == 0); s_gnt = (i == 0); s_rdata = 32'h7777_7777;
      #1;
      check1("late_rv0", m0_rvalid, 1'b0);
      check1("late_rv1", m1_rvalid, 1'b0);
      check1("late_sreq", s_req, 1'b0);
    end
    do_txn(1'b1, 1'b1, 32'h900, 32'h904, 32'h0, 32'h0, 2'b00, 4'hF, 4'hF,
           0, 1, 32'h9999_0000, 1'b0, 0);

    @(negedge clk);
    s_gnt = 1'b0; s_rvalid = 1'b0;
    #1;
    check1("final_rv0", m0_rvalid, 1'b0);
    check1("final_rv1", m1_rvalid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
